pwm_uart_loader: RTL

PWM_UART_LOADER -- requirements
Module: pwm_uart_loader

---
 rtl/pwm_uart_loader.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_uart_loader.sv
// pwm_uart_loader
//   Receives 3-byte frames {address, data, checksum} over an 8N1 UART line and
//   turns each frame whose checksum matches into a single write strobe to a
//   PWM period register file.
//
// Ports
//   CLK_100MHz  in   1  sole clock, rising edge
//   RST         in   1  synchronous active-high reset
//   rx          in   1  asynchronous UART line, idle high, LSB first
//   wr_en       out  1  one-cycle write strobe
//   wr_addr     out  8  PWM channel index, held until the next strobe
//   wr_data     out  8  PWM period value, held until the next strobe
//   frame_err   out  1  one-cycle pulse on framing, checksum or timeout error
//   busy        out  1  high while a frame or a confirmed byte is in progress
module pwm_uart_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          TIMEOUT_CLKS = 1000000,
  parameter logic [7:0]  CSUM_KEY     = 8'hA5
) (
  input  logic       CLK_100MHz,
  input  logic       RST,
  input  logic       rx,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] HALF_M1    = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_M1     = 16'(CLKS_PER_BIT - 1);
  localparam logic [23:0] TIMEOUT_M1 = 24'(TIMEOUT_CLKS - 1);
  localparam logic [23:0] IDLE_MAX   = 24'hFFFFFF;

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
  typedef enum logic [1:0] {F_ADDR, F_DATA, F_CSUM}          frame_state_t;

  logic         r_rx_meta;
  logic         r_rx_sync;

  bit_state_t   r_bit_state,  w_bit_next;
  logic [15:0]  r_clk_cnt,    w_clk_cnt_next;
  logic [2:0]   r_bit_cnt,    w_bit_cnt_next;
  logic [7:0]   r_shift,      w_shift_next;
  logic         r_err_hold,   w_err_hold_next;
  logic         w_byte_valid;
  logic         w_stop_err;

  frame_state_t r_frame_state, w_frame_next;
  logic [7:0]   r_addr_buf,    w_addr_buf_next;
  logic [7:0]   r_data_buf,    w_data_buf_next;
  logic [23:0]  r_idle_cnt,    w_idle_cnt_next;
  logic         w_timeout;

  logic         r_wr_en,     w_wr_en_next;
  logic [7:0]   r_wr_addr,   w_wr_addr_next;
  logic [7:0]   r_wr_data,   w_wr_data_next;
  logic         r_frame_err, w_frame_err_next;
  logic         r_busy,      w_busy_next;

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

  // Two-flop synchronizer for the asynchronous rx line; resets to idle-high.
  always_ff @(posedge CLK_100MHz) begin
    if (RST) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Bit FSM next-state: start detect, mid-bit sampling, stop check.
  always_comb begin
    w_bit_next      = r_bit_state;
    w_clk_cnt_next  = r_clk_cnt + 16'd1;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_err_hold_next = r_err_hold;
    w_byte_valid    = 1'b0;
    w_stop_err      = 1'b0;
    case (r_bit_state)
      B_IDLE: begin
        w_clk_cnt_next = 16'd0;
        if (!r_rx_sync) begin
          w_bit_next     = B_START;
          w_bit_cnt_next = 3'd0;
        end else begin
          w_bit_next = B_IDLE;
        end
      end
      B_START: begin
        if (r_clk_cnt == HALF_M1) begin
          w_clk_cnt_next = 16'd0;
          // A line that is high again by mid-start-bit was only a glitch.
          if (!r_rx_sync) begin
            w_bit_next = B_DATA;
          end else begin
            w_bit_next = B_IDLE;
          end
        end else begin
          w_bit_next = B_START;
        end
      end
      B_DATA: begin
        if (r_clk_cnt == BIT_M1) begin
          w_clk_cnt_next = 16'd0;
          w_shift_next   = {r_rx_sync, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_bit_next = B_STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end
        end else begin
          w_bit_next = B_DATA;
        end
      end
      B_STOP: begin
        if (r_err_hold) begin
          // After a bad stop bit, wait for the line to return high so the
          // still-low line is not mistaken for a new start bit.
          w_clk_cnt_next = 16'd0;
          if (r_rx_sync) begin
            w_bit_next      = B_IDLE;
            w_err_hold_next = 1'b0;
          end else begin
            w_bit_next = B_STOP;
          end
        end else if (r_clk_cnt == BIT_M1) begin
          w_clk_cnt_next = 16'd0;
          if (r_rx_sync) begin
            w_byte_valid = 1'b1;
            w_bit_next   = B_IDLE;
          end else begin
            w_stop_err      = 1'b1;
            w_err_hold_next = 1'b1;
          end
        end else begin
          w_bit_next = B_STOP;
        end
      end
      default: begin
        w_bit_next      = B_IDLE;
        w_clk_cnt_next  = 16'd0;
        w_err_hold_next = 1'b0;
      end
    endcase
  end

  // Bit FSM state and datapath registers.
  always_ff @(posedge CLK_100MHz) begin
    if (RST) begin
      r_bit_state <= B_IDLE;
      r_clk_cnt   <= 16'd0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_err_hold  <= 1'b0;
    end else begin
      r_bit_state <= w_bit_next;
      r_clk_cnt   <= w_clk_cnt_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_shift     <= w_shift_next;
      r_err_hold  <= w_err_hold_next;
    end
  end

  // Timeout fires on the cycle the idle counter would reach TIMEOUT_CLKS.
  assign w_timeout = (r_frame_state != F_ADDR) && (r_bit_state == B_IDLE) &&
                     (r_idle_cnt == TIMEOUT_M1);

  // Frame FSM next-state, checksum compare, idle counter and output strobes.
  always_comb begin
    w_frame_next     = r_frame_state;
    w_addr_buf_next  = r_addr_buf;
    w_data_buf_next  = r_data_buf;
    w_wr_en_next     = 1'b0;
    w_wr_addr_next   = r_wr_addr;
    w_wr_data_next   = r_wr_data;
    w_frame_err_next = 1'b0;
    w_idle_cnt_next  = r_idle_cnt;

    // Stop errors, timeouts and byte deliveries are mutually exclusive in a
    // cycle, so each error event yields exactly one frame_err pulse.
    if (w_stop_err) begin
      w_frame_err_next = 1'b1;
      w_frame_next     = F_ADDR;
    end else if (w_timeout) begin
      w_frame_err_next = 1'b1;
      w_frame_next     = F_ADDR;
    end else if (w_byte_valid) begin
      case (r_frame_state)
        F_ADDR: begin
          w_addr_buf_next = r_shift;
          w_frame_next    = F_DATA;
        end
        F_DATA: begin
          w_data_buf_next = r_shift;
          w_frame_next    = F_CSUM;
        end
        F_CSUM: begin
          if (r_shift == (r_addr_buf ^ r_data_buf ^ CSUM_KEY)) begin
            w_wr_en_next   = 1'b1;
            w_wr_addr_next = r_addr_buf;
            w_wr_data_next = r_data_buf;
          end else begin
            w_frame_err_next = 1'b1;
          end
          w_frame_next = F_ADDR;
        end
        default: begin
          w_frame_next = F_ADDR;
        end
      endcase
    end else begin
      w_frame_next = r_frame_state;
    end

    if (w_byte_valid || (r_frame_state == F_ADDR)) begin
      w_idle_cnt_next = 24'd0;
    end else if ((r_bit_state == B_IDLE) && (r_idle_cnt != IDLE_MAX)) begin
      w_idle_cnt_next = r_idle_cnt + 24'd1;
    end else begin
      w_idle_cnt_next = r_idle_cnt;
    end

    // A byte counts as in progress only once its start bit is confirmed,
    // so rejected glitches never raise busy.
    w_busy_next = (w_frame_next != F_ADDR) || (w_bit_next == B_DATA) ||
                  (w_bit_next == B_STOP);
  end

  // Frame FSM state and registered outputs.
  always_ff @(posedge CLK_100MHz) begin
    if (RST) begin
      r_frame_state <= F_ADDR;
      r_addr_buf    <= 8'h00;
      r_data_buf    <= 8'h00;
      r_idle_cnt    <= 24'd0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= 8'h00;
      r_wr_data     <= 8'h00;
      r_frame_err   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_frame_state <= w_frame_next;
      r_addr_buf    <= w_addr_buf_next;
      r_data_buf    <= w_data_buf_next;
      r_idle_cnt    <= w_idle_cnt_next;
      r_wr_en       <= w_wr_en_next;
      r_wr_addr     <= w_wr_addr_next;
      r_wr_data     <= w_wr_data_next;
      r_frame_err   <= w_frame_err_next;
      r_busy        <= w_busy_next;
    end
  end

endmodule
